lsm_sequencer: RTL and testbench
================================

# lsm_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It accepts one decoded block-transfer instruction plus the base register value. It then walks the register list lowest-first, issuing one word transfer per set bit over a req/ack memory handshake, and produces the base-register writeback value. It sits beside the single-transfer address generator in the execute stage and owns the memory port while busy.

## Interface
- ADDR_W, 32, address/data width; fixed at 32 for ARM.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous, active-low reset
- START  in  1  one-cycle request; OPCODE and BASE are sampled only on this cycle
- OPCODE  in  32  instruction; used fields: [27:25] class, [24] P, [23] U, [21] W, [20] L, [19:16] Rn, [15:0] register list
- BASE  in  32  current value of Rn
- BUSY  out  1  sequencer owns the memory port
- MEM_REQ  out  1  transfer request
- MEM_ADDR  out  32  word address, [1:0] always 00
- MEM_WE  out  1  1 = store (L=0), 0 = load
- MEM_ACK  in  1  transfer completes on a cycle where MEM_REQ && MEM_ACK
- REG_IDX  out  4  register for the current beat
- REG_LD  out  1  MEM_REQ && MEM_ACK && L, combinational; the register file writes REG_IDX
- WB_EN  out  1  one-cycle base writeback strobe
- WB_VAL  out  32  new Rn value, valid with WB_EN
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle rejection pulse

## Operation
- States: IDLE, SETUP, XFER, FIN.
- IDLE: on START, validate the request.
  - OPCODE[27:25]==3'b100 with a non-zero list: go to SETUP.
  - Otherwise: ERR=1 next cycle, remain in IDLE.
- START outside IDLE is ignored.
- SETUP (1 cycle): compute N = popcount(list) and the start address A0 from BASE with [1:0] forced to 00:
  - IA (P0 U1): A0 = BASE
  - IB (P1 U1): A0 = BASE+4
  - DA (P0 U0): A0 = BASE−4N+4
  - DB (P1 U0): A0 = BASE−4N
- SETUP also latches the list into a working mask, latches L, W and Rn, and loads REG_IDX with the lowest set bit.
- XFER: MEM_REQ=1, MEM_WE=!L. On each ACK:
  - clear the current bit;
  - next cycle: MEM_ADDR += 4 and REG_IDX = next lowest set bit;
  - on the last ACK, go to FIN.
  - With no ACK, MEM_ADDR, REG_IDX and MEM_WE hold.
- FIN (1 cycle): DONE=1, then go to IDLE.
  - WB_VAL = BASE+4N if U=1, else BASE−4N (uses unmasked BASE).
  - WB_EN = W && !(L && list[Rn]): for a load that includes the base register, the loaded value wins.
- Arithmetic is modulo 2^32; address wrap is silent.
- MEM_ACK outside XFER is ignored.
- S bit [22] and the condition field are ignored; both are handled upstream.

## Timing
- Reset (RST_N low at any edge, including mid-XFER): state IDLE, and every output is 0 (BUSY, MEM_REQ, MEM_ADDR, MEM_WE, REG_IDX, WB_EN, WB_VAL, DONE, ERR). An in-flight request is dropped without completion.
- START accepted at cycle t:
  - SETUP at t+1;
  - MEM_REQ first high at t+2;
  - with ACK every cycle, beats occupy t+2 … t+N+1;
  - FIN (DONE, WB_EN) at t+N+2;
  - IDLE at t+N+3, where the next START is accepted.
- BUSY is high from t+1 through FIN inclusive.
- MEM_REQ stays continuously high between back-to-back beats and drops the cycle after the last ACK.
- ERR is asserted at t+1; BUSY stays 0.
- All outputs are registered except REG_LD.

## Structure
- Shared package arm_defs:
  - state encoding (IDLE/SETUP/XFER/FIN);
  - OPCODE field positions (P=24, U=23, W=21, L=20, RN_HI=19, RN_LO=16);
  - class constant LSM_CLASS=3'b100.
- Sub-module lsm_reg_scan: combinational, takes a 16-bit mask and returns the 5-bit popcount and the 4-bit lowest-set index. The instance at the working mask supplies REG_IDX.

## Test plan
- STM IA, BASE=0x1000, list=0x000E, W=1, ACK every cycle:
  - addresses 0x1000/0x1004/0x1008 with REG_IDX 1/2/3 and MEM_WE=1;
  - DONE at t+5 with WB_EN=1, WB_VAL=0x100C.
- LDM DB, BASE=0x2000, list=0x8001, W=1:
  - 0x1FF8 (r0), then 0x1FFC (r15);
  - REG_LD pulses on both ACKs; WB_VAL=0x1FF8.
- LDM IA, Rn=2, list=0x0004, W=1: one beat at BASE, DONE=1, WB_EN stays 0.
- STM IB, BASE=0x10, list=0x0003, first ACK delayed 3 cycles:
  - MEM_ADDR=0x14 and REG_IDX=0 held with MEM_REQ high for 3 cycles;
  - then 0x18 with REG_IDX=1.
- STM DA, BASE=0x4, list=0x0007: addresses 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004 (wrap); WB_VAL=0xFFFF_FFF8 when W=1.
- Rejection and reset:
  - START with list=0 → ERR one cycle, BUSY 0;
  - START with OPCODE[27:25]=010 → ERR;
  - START while BUSY → ignored;
  - RST_N low during the second beat → all outputs 0 next cycle, and a following START runs normally.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared ARM decode definitions for the block-transfer sequencer:
// FSM state encoding, OPCODE field positions and start-address helper.
package arm_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_FIN   = 2'd3
  } lsm_state_t;

  localparam int P     = 24;
  localparam int U     = 23;
  localparam int W     = 21;
  localparam int L     = 20;
  localparam int RN_HI = 19;
  localparam int RN_LO = 16;

  localparam logic [2:0] LSM_CLASS = 3'b100;

  // First transfer address for the four addressing modes; the base is
  // word-aligned first, and arithmetic wraps modulo 2^32.
  function automatic logic [31:0] lsm_start_addr(input logic [31:0] base,
                                                 input logic        p,
                                                 input logic        u,
                                                 input logic [4:0]  n);
    logic [31:0] bm;
    logic [31:0] n4;
    bm = {base[31:2], 2'b00};
    n4 = {25'd0, n, 2'b00};
    case ({p, u})
      2'b01:   return bm;                  // IA
      2'b11:   return bm + 32'd4;          // IB
      2'b00:   return bm - n4 + 32'd4;     // DA
      default: return bm - n4;             // DB
    endcase
  endfunction

endpackage

// File: rtl/lsm_reg_scan.sv
// Register-list scanner: population count and index of the lowest set bit.
module lsm_reg_scan (
  input  logic [15:0] mask,
  output logic [4:0]  count,
  output logic [3:0]  lowest
);

  // Walk high-to-low so the last hit left in lowest is the lowest set bit.
  always_comb begin
    count  = '0;
    lowest = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        count  = count + 5'd1;
        lowest = 4'(i);
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, one word per
// set bit over a req/ack port, then emits the base writeback value.
module lsm_sequencer
  import arm_defs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] OPCODE,
  input  logic [ADDR_W-1:0] BASE,
  output logic              BUSY,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  input  logic              MEM_ACK,
  output logic [3:0]        REG_IDX,
  output logic              REG_LD,
  output logic              WB_EN,
  output logic [ADDR_W-1:0] WB_VAL,
  output logic              DONE,
  output logic              ERR
);

  lsm_state_t        state;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] base_q;
  logic              p_q, u_q, w_q, l_q;
  logic [3:0]        rn_q;
  logic [15:0]       mask;
  logic [ADDR_W-1:0] wb_q;
  logic              wb_en_q;

  logic [4:0]        n_setup;
  logic [3:0]        low_setup;
  logic [15:0]       mask_nxt;
  logic [4:0]        n_nxt;
  logic [3:0]        low_nxt;
  logic [ADDR_W-1:0] n4;
  logic              valid_req;

  // Condition field and S bit are resolved upstream.
  logic unused_fields;
  assign unused_fields = ^{OPCODE[31:28], OPCODE[22]};

  assign valid_req = (OPCODE[27:25] == LSM_CLASS) && (|OPCODE[15:0]);
  assign n4        = {{(ADDR_W-7){1'b0}}, n_setup, 2'b00};
  assign mask_nxt  = mask & ~(16'd1 << REG_IDX);
  assign REG_LD    = MEM_REQ && MEM_ACK && l_q;

  // Full list: beat count and first register, used in SETUP.
  lsm_reg_scan u_scan_list (
    .mask   (list_q),
    .count  (n_setup),
    .lowest (low_setup)
  );

  // Working mask with the current beat removed: next register and last-beat test.
  lsm_reg_scan u_scan_work (
    .mask   (mask_nxt),
    .count  (n_nxt),
    .lowest (low_nxt)
  );

  // Sequencer FSM with registered outputs; reset clears every output.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      list_q   <= '0;
      base_q   <= '0;
      p_q      <= 1'b0;
      u_q      <= 1'b0;
      w_q      <= 1'b0;
      l_q      <= 1'b0;
      rn_q     <= '0;
      mask     <= '0;
      wb_q     <= '0;
      wb_en_q  <= 1'b0;
      BUSY     <= 1'b0;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WE   <= 1'b0;
      REG_IDX  <= '0;
      WB_EN    <= 1'b0;
      WB_VAL   <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ERR   <= 1'b0;
      DONE  <= 1'b0;
      WB_EN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (valid_req) begin
              list_q <= OPCODE[15:0];
              base_q <= BASE;
              p_q    <= OPCODE[P];
              u_q    <= OPCODE[U];
              w_q    <= OPCODE[W];
              l_q    <= OPCODE[L];
              rn_q   <= OPCODE[RN_HI:RN_LO];
              BUSY   <= 1'b1;
              state  <= ST_SETUP;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          mask     <= list_q;
          REG_IDX  <= low_setup;
          MEM_ADDR <= lsm_start_addr(base_q, p_q, u_q, n_setup);
          MEM_WE   <= !l_q;
          MEM_REQ  <= 1'b1;
          // Writeback uses the unaligned base; a load of Rn overrides it.
          wb_q     <= u_q ? (base_q + n4) : (base_q - n4);
          wb_en_q  <= w_q && !(l_q && list_q[rn_q]);
          state    <= ST_XFER;
        end
        ST_XFER: begin
          if (MEM_ACK) begin
            mask <= mask_nxt;
            if (n_nxt == 5'd0) begin
              MEM_REQ <= 1'b0;
              DONE    <= 1'b1;
              WB_EN   <= wb_en_q;
              WB_VAL  <= wb_q;
              state   <= ST_FIN;
            end else begin
              MEM_ADDR <= MEM_ADDR + 32'd4;
              REG_IDX  <= low_nxt;
            end
          end
        end
        ST_FIN: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: addressing modes, wait states,
// writeback suppression, rejection, busy-ignore and mid-transfer reset.
module tb_lsm_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [31:0] OPCODE;
  logic [31:0] BASE;
  logic        BUSY;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_WE;
  logic        MEM_ACK;
  logic [3:0]  REG_IDX;
  logic        REG_LD;
  logic        WB_EN;
  logic [31:0] WB_VAL;
  logic        DONE;
  logic        ERR;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  lsm_sequencer #(.ADDR_W(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .OPCODE   (OPCODE),
    .BASE     (BASE),
    .BUSY     (BUSY),
    .MEM_REQ  (MEM_REQ),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WE   (MEM_WE),
    .MEM_ACK  (MEM_ACK),
    .REG_IDX  (REG_IDX),
    .REG_LD   (REG_LD),
    .WB_EN    (WB_EN),
    .WB_VAL   (WB_VAL),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] idx,
                      input logic we, input logic ld);
    chk({tag, "_req"},  {31'd0, MEM_REQ}, 32'd1);
    chk({tag, "_addr"}, MEM_ADDR, a);
    chk({tag, "_idx"},  {28'd0, REG_IDX}, {28'd0, idx});
    chk({tag, "_we"},   {31'd0, MEM_WE}, {31'd0, we});
    chk({tag, "_ld"},   {31'd0, REG_LD}, {31'd0, ld});
  endtask

  function automatic logic [31:0] mk(input logic p, input logic u, input logic w,
                                     input logic l, input logic [3:0] rn,
                                     input logic [15:0] list);
    return {4'hE, 3'b100, p, u, 1'b0, w, l, rn, list};
  endfunction

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic go(input logic [31:0] op, input logic [31:0] base);
    START  = 1'b1;
    OPCODE = op;
    BASE   = base;
    tick();
    START  = 1'b0;
  endtask

  task automatic fin(input string tag, input logic wb_en, input logic [31:0] wb_val);
    chk({tag, "_done"},  {31'd0, DONE}, 32'd1);
    chk({tag, "_wben"},  {31'd0, WB_EN}, {31'd0, wb_en});
    if (wb_en) chk({tag, "_wbval"}, WB_VAL, wb_val);
    chk({tag, "_reqoff"}, {31'd0, MEM_REQ}, 32'd0);
    chk({tag, "_busy"},  {31'd0, BUSY}, 32'd1);
  endtask

  logic [31:0] op;

  initial begin
    RST_N = 1'b0; START = 1'b0; OPCODE = '0; BASE = '0; MEM_ACK = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_req",  {31'd0, MEM_REQ}, 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err",  {31'd0, ERR}, 32'd0);
    RST_N = 1'b1;
    tick();

    // STM IA, ACK held high throughout (ignored before XFER)
    MEM_ACK = 1'b1;
    go(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 16'h000E), 32'h0000_1000);
    chk("t1_setup_busy", {31'd0, BUSY}, 32'd1);
    chk("t1_setup_req",  {31'd0, MEM_REQ}, 32'd0);
    tick(); beat("t1_b0", 32'h1000, 4'd1, 1'b1, 1'b0);
    tick(); beat("t1_b1", 32'h1004, 4'd2, 1'b1, 1'b0);
    tick(); beat("t1_b2", 32'h1008, 4'd3, 1'b1, 1'b0);
    tick(); fin("t1", 1'b1, 32'h0000_100C);
    tick();
    chk("t1_idle_done", {31'd0, DONE}, 32'd0);
    chk("t1_idle_busy", {31'd0, BUSY}, 32'd0);

    // LDM DB with r0 and r15
    go(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h8001), 32'h0000_2000);
    tick(); beat("t2_b0", 32'h1FF8, 4'd0,  1'b0, 1'b1);
    tick(); beat("t2_b1", 32'h1FFC, 4'd15, 1'b0, 1'b1);
    tick(); fin("t2", 1'b1, 32'h0000_1FF8);
    tick();

    // LDM IA including the base register: writeback suppressed
    go(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0004), 32'h0000_0300);
    tick(); beat("t3_b0", 32'h0300, 4'd2, 1'b0, 1'b1);
    tick(); fin("t3", 1'b0, 32'h0);
    tick();

    // STM IB with the first ACK delayed three cycles
    MEM_ACK = 1'b0;
    go(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0003), 32'h0000_0010);
    tick(); beat("t4_w0", 32'h14, 4'd0, 1'b1, 1'b0);
    tick(); beat("t4_w1", 32'h14, 4'd0, 1'b1, 1'b0);
    tick(); beat("t4_w2", 32'h14, 4'd0, 1'b1, 1'b0);
    MEM_ACK = 1'b1;
    tick(); beat("t4_b1", 32'h18, 4'd1, 1'b1, 1'b0);
    tick(); fin("t4", 1'b0, 32'h0);
    tick();

    // STM DA wrapping below zero
    go(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h0007), 32'h0000_0004);
    tick(); beat("t5_b0", 32'hFFFF_FFFC, 4'd0, 1'b1, 1'b0);
    tick(); beat("t5_b1", 32'h0000_0000, 4'd1, 1'b1, 1'b0);
    tick(); beat("t5_b2", 32'h0000_0004, 4'd2, 1'b1, 1'b0);
    tick(); fin("t5", 1'b1, 32'hFFFF_FFF8);
    tick();

    // Rejections: empty list, wrong class
    go(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000), 32'h0000_0100);
    chk("t6_empty_err",  {31'd0, ERR}, 32'd1);
    chk("t6_empty_busy", {31'd0, BUSY}, 32'd0);
    tick();
    chk("t6_err_clear",  {31'd0, ERR}, 32'd0);
    op = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0001);
    op[27:25] = 3'b010;
    go(op, 32'h0000_0100);
    chk("t6_class_err",  {31'd0, ERR}, 32'd1);
    chk("t6_class_busy", {31'd0, BUSY}, 32'd0);
    tick();

    // START held while busy is ignored (would otherwise raise ERR)
    go(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0003), 32'h0000_0100);
    START = 1'b1; OPCODE = op; BASE = 32'h0;
    tick(); beat("t7_b0", 32'h0100, 4'd0, 1'b1, 1'b0);
    chk("t7_no_err", {31'd0, ERR}, 32'd0);
    START = 1'b0;
    tick(); beat("t7_b1", 32'h0104, 4'd1, 1'b1, 1'b0);
    tick(); fin("t7", 1'b0, 32'h0);
    tick();
    chk("t7_idle_busy", {31'd0, BUSY}, 32'd0);
    chk("t7_idle_err",  {31'd0, ERR}, 32'd0);

    // Reset during the second beat, then a normal transfer
    go(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h000F), 32'h0000_0500);
    tick(); beat("t8_b0", 32'h0500, 4'd0, 1'b0, 1'b1);
    tick(); beat("t8_b1", 32'h0504, 4'd1, 1'b0, 1'b1);
    RST_N = 1'b0;
    tick();
    chk("t8_rst_busy",  {31'd0, BUSY}, 32'd0);
    chk("t8_rst_req",   {31'd0, MEM_REQ}, 32'd0);
    chk("t8_rst_addr",  MEM_ADDR, 32'd0);
    chk("t8_rst_we",    {31'd0, MEM_WE}, 32'd0);
    chk("t8_rst_idx",   {28'd0, REG_IDX}, 32'd0);
    chk("t8_rst_ld",    {31'd0, REG_LD}, 32'd0);
    chk("t8_rst_wben",  {31'd0, WB_EN}, 32'd0);
    chk("t8_rst_wbval", WB_VAL, 32'd0);
    chk("t8_rst_done",  {31'd0, DONE}, 32'd0);
    chk("t8_rst_err",   {31'd0, ERR}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("t8_post_busy", {31'd0, BUSY}, 32'd0);
    go(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0010), 32'h0000_0040);
    chk("t8_restart_busy", {31'd0, BUSY}, 32'd1);
    tick(); beat("t8_r0", 32'h0040, 4'd4, 1'b1, 1'b0);
    tick(); fin("t8r", 1'b1, 32'h0000_0044);
    tick();
    chk("t8_end_busy", {31'd0, BUSY}, 32'd0);
    MEM_ACK = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
